roi_line_packer: RTL and testbench
==================================

ROI_LINE_PACKER -- requirements
Module: roi_line_packer

Interface
REQ-001 SHALL have parameter WIDTH, default 800, max large-area x coordinate (line up to WIDTH+1 pixels).
REQ-002 SHALL have parameter HEIGHT, default 600, max large-area y coordinate.
REQ-003 SHALL have parameter BIT_D, default 8, pixel width.
REQ-004 SHALL have parameter DEPTH, default 1024, FIFO entries, power of two, >=4.
REQ-005 SHALL have one clock and an asynchronous, active-low reset; port names are the clk_i and arst_n_i ports below.
REQ-006 clk_i  in  1  clock, all logic on rising edge.
REQ-007 arst_n_i  in  1  asynchronous reset, active low.
REQ-008 tdata_i  in  BIT_D  cropped ROI pixel from the ROI cropper.
REQ-009 tvalid_i  in  1  pixel valid; upstream has no stall, so every valid beat is presented exactly once.
REQ-010 tlast_i  in  1  last pixel of ROI frame, qualified by tvalid_i.
REQ-011 roi_w_i  in  11  ROI line length in pixels, sampled at first pixel of frame.
REQ-012 m_tdata_o  out  BIT_D  output pixel.
REQ-013 m_tvalid_o  out  1  output beat valid.
REQ-014 m_tready_i  in  1  downstream ready.
REQ-015 m_tuser_o  out  1  start of frame, high on first beat of frame only.
REQ-016 m_tlast_o  out  1  end of line, high on last beat of each line.
REQ-017 ovf_o  out  1  sticky overflow flag, cleared only by reset.
REQ-018 level_o  out  $clog2(DEPTH)+1  current FIFO occupancy.

Function
REQ-019 Write FSM states: WAIT_SOF, IN_FRAME, DROP.
REQ-020 WAIT_SOF: on tvalid_i, latch roi_w_i; if 1 <= roi_w_i <= WIDTH+1 write beat with sof=1, go IN_FRAME (or stay WAIT_SOF if tlast_i also high); else discard beat, go DROP (or stay WAIT_SOF if tlast_i).
REQ-021 IN_FRAME: each tvalid_i beat written with sof=0; column counter increments; eol=1 when column == latched width-1 or tlast_i; column wraps to 0 after eol.
REQ-022 tvalid_i && tlast_i in IN_FRAME: write beat with eol=1, reset column, go WAIT_SOF.
REQ-023 DROP: discard all beats; tvalid_i && tlast_i returns to WAIT_SOF.
REQ-024 FIFO entry = {sof, eol, data}; m_tuser_o/m_tlast_o/m_tdata_o driven from head entry.
REQ-025 Pop occurs when m_tvalid_o && m_tready_i; m_tvalid_o == (level_o != 0).
REQ-026 Latency: beat written at edge N appears on m_tvalid_o after edge N (first-word fall-through), no bubble between consecutive entries under m_tready_i=1.
REQ-027 Output beat SHALL hold data/sideband stable while m_tvalid_o && !m_tready_i.
REQ-028 Full (level == DEPTH): write accepted only if pop in same cycle; otherwise beat discarded, ovf_o set, FSM goes DROP unless beat carries tlast_i (then WAIT_SOF).
REQ-029 Simultaneous write and pop: level unchanged; empty FIFO write+no pop: level 1 next cycle.
REQ-030 Pointers wrap modulo DEPTH; level never exceeds DEPTH nor underflows.
REQ-031 A frame that overflows is truncated; the already-queued head of that frame still drains unchanged.

Reset
REQ-032 arst_n_i low SHALL asynchronously force: FSM WAIT_SOF, pointers and level 0, column 0, ovf_o 0, m_tvalid_o 0, m_tuser_o 0, m_tlast_o 0, m_tdata_o 0.
REQ-033 Reset mid-frame discards all queued entries; first tvalid_i after release is treated as start of frame.

Structure
REQ-034 Shared package roi_pkg SHALL hold BIT_D/WIDTH/HEIGHT defaults and the write-FSM state typedef.
REQ-035 FIFO storage SHALL be a sub-module roi_sync_fifo (parameters DEPTH, data width BIT_D+2); FSM and column counter stay in roi_line_packer.

Verification
REQ-036 roi_w_i=4, 12 beats 0..11 with tlast_i on beat 11, m_tready_i=1 -> 12 out beats data 0..11, tuser on beat 0, tlast on beats 3,7,11, ovf_o=0.
REQ-037 Same frame, m_tready_i toggling 1/0 each cycle -> identical output sequence, outputs stable while stalled, level_o peaks then returns 0.
REQ-038 DEPTH=16, m_tready_i=0, 20 beats roi_w_i=4 -> first 16 queued, ovf_o=1 at beat 17, FSM DROP until tlast_i; then m_tready_i=1 -> 16 beats out, tlast on 3,7,11,15.
REQ-039 roi_w_i=5, tlast_i on beat 7 -> tlast on beats 4 and 7; next frame beat carries tuser.
REQ-040 roi_w_i=0 frame of 6 beats, then roi_w_i=3 frame of 3 beats -> only second frame output, tuser on its beat 0, tlast on its beat 2.
REQ-041 arst_n_i low for 1 cycle after 5 beats of a 12-beat frame -> m_tvalid_o=0, level_o=0 immediately; next beat emitted with tuser=1.

Source files
------------

// File: rtl/roi_pkg.sv
// rtl/roi_pkg.sv - shared defaults and write-FSM state encoding for the ROI line packer
package roi_pkg;

    localparam int unsigned ROI_WIDTH  = 800;
    localparam int unsigned ROI_HEIGHT = 600;
    localparam int unsigned ROI_BIT_D  = 8;

    typedef logic [1:0] wr_state_t;

    localparam wr_state_t WAIT_SOF = 2'd0;
    localparam wr_state_t IN_FRAME = 2'd1;
    localparam wr_state_t DROP     = 2'd2;

endpackage

// File: rtl/roi_sync_fifo.sv
// rtl/roi_sync_fifo.sv - first-word fall-through synchronous FIFO, head reads as zero when empty
module roi_sync_fifo #(
    parameter int DEPTH = 1024,
    parameter int DW    = 10
) (
    input  logic                     clk,
    input  logic                     arst_n,
    input  logic                     wr_en,
    input  logic [DW-1:0]            wr_data,
    input  logic                     rd_en,
    output logic [DW-1:0]            rd_data,
    output logic                     valid,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_wr;
    logic          do_rd;

    assign valid   = (level != '0);
    assign full    = (level == (AW+1)'(DEPTH));
    assign do_rd   = rd_en && valid;
    // A write into a full FIFO is only safe when the head is leaving on the same edge.
    assign do_wr   = wr_en && (!full || do_rd);
    assign rd_data = valid ? mem[rd_ptr] : '0;

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + 1'b1;
            if (do_rd) rd_ptr <= rd_ptr + 1'b1;
            case ({do_wr, do_rd})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/roi_line_packer.sv
// rtl/roi_line_packer.sv - splits cropped ROI pixel stream into lines with SOF/EOL sideband
module roi_line_packer
    import roi_pkg::*;
#(
    parameter int WIDTH  = ROI_WIDTH,
    parameter int HEIGHT = ROI_HEIGHT,
    parameter int BIT_D  = ROI_BIT_D,
    parameter int DEPTH  = 1024
) (
    input  logic                       clk_i,
    input  logic                       arst_n_i,
    input  logic [BIT_D-1:0]           tdata_i,
    input  logic                       tvalid_i,
    input  logic                       tlast_i,
    input  logic [10:0]                roi_w_i,
    output logic [BIT_D-1:0]           m_tdata_o,
    output logic                       m_tvalid_o,
    input  logic                       m_tready_i,
    output logic                       m_tuser_o,
    output logic                       m_tlast_o,
    output logic                       ovf_o,
    output logic [$clog2(DEPTH):0]     level_o
);

    localparam logic [11:0] MAX_W = 12'(WIDTH + 1);

    wr_state_t   state;
    wr_state_t   state_nxt;
    logic [10:0] col;
    logic [10:0] col_nxt;
    logic [10:0] width_q;
    logic        wr_req;
    logic        wr_sof;
    logic        wr_eol;
    logic        wr_ok;
    logic        pop;
    logic        full;
    logic        width_ok;
    logic [BIT_D+1:0] head;

    assign pop      = m_tvalid_o && m_tready_i;
    assign wr_ok    = wr_req && (!full || pop);
    assign width_ok = (roi_w_i != 11'd0) && ({1'b0, roi_w_i} <= MAX_W);

    always_comb begin
        state_nxt = state;
        col_nxt   = col;
        wr_req    = 1'b0;
        wr_sof    = 1'b0;
        wr_eol    = 1'b0;
        case (state)
            WAIT_SOF: begin
                if (tvalid_i) begin
                    if (width_ok) begin
                        wr_req = 1'b1;
                        wr_sof = 1'b1;
                        wr_eol = tlast_i || (roi_w_i == 11'd1);
                        if (wr_ok) begin
                            state_nxt = tlast_i ? WAIT_SOF : IN_FRAME;
                            col_nxt   = wr_eol ? 11'd0 : 11'd1;
                        end else begin
                            state_nxt = tlast_i ? WAIT_SOF : DROP;
                            col_nxt   = 11'd0;
                        end
                    end else begin
                        state_nxt = tlast_i ? WAIT_SOF : DROP;
                    end
                end
            end
            IN_FRAME: begin
                if (tvalid_i) begin
                    wr_req = 1'b1;
                    wr_eol = tlast_i || (col == width_q - 11'd1);
                    if (wr_ok) begin
                        state_nxt = tlast_i ? WAIT_SOF : IN_FRAME;
                        col_nxt   = wr_eol ? 11'd0 : col + 11'd1;
                    end else begin
                        // Overflow truncates the frame; what is already queued still drains.
                        state_nxt = tlast_i ? WAIT_SOF : DROP;
                        col_nxt   = 11'd0;
                    end
                end
            end
            DROP: begin
                if (tvalid_i && tlast_i) state_nxt = WAIT_SOF;
            end
            default: state_nxt = WAIT_SOF;
        endcase
    end

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            state   <= WAIT_SOF;
            col     <= '0;
            width_q <= '0;
            ovf_o   <= 1'b0;
        end else begin
            state <= state_nxt;
            col   <= col_nxt;
            if (state == WAIT_SOF && tvalid_i) width_q <= roi_w_i;
            if (wr_req && !wr_ok) ovf_o <= 1'b1;
        end
    end

    roi_sync_fifo #(
        .DEPTH (DEPTH),
        .DW    (BIT_D + 2)
    ) u_fifo (
        .clk     (clk_i),
        .arst_n  (arst_n_i),
        .wr_en   (wr_ok),
        .wr_data ({wr_sof, wr_eol, tdata_i}),
        .rd_en   (pop),
        .rd_data (head),
        .valid   (m_tvalid_o),
        .full    (full),
        .level   (level_o)
    );

    assign m_tuser_o = head[BIT_D+1];
    assign m_tlast_o = head[BIT_D];
    assign m_tdata_o = head[BIT_D-1:0];

endmodule

// File: tb/tb_roi_line_packer.sv
// tb/tb_roi_line_packer.sv - directed self-checking bench for roi_line_packer
module tb_roi_line_packer;

    logic        clk_i = 1'b0;
    logic        arst_n_i;
    logic [7:0]  tdata_i;
    logic        tvalid_i;
    logic        tlast_i;
    logic [10:0] roi_w_i;
    logic [7:0]  m_tdata_o;
    logic        m_tvalid_o;
    logic        m_tready_i;
    logic        m_tuser_o;
    logic        m_tlast_o;
    logic        ovf_o;
    logic [4:0]  level_o;

    int n_cmp = 0;
    int n_bad = 0;
    bit toggle = 0;
    logic [9:0] got[$];
    logic [9:0] exp_q[$];
    logic [10:0] held;
    bit prev_stall = 0;
    int peak = 0;

    roi_line_packer #(.WIDTH(800), .HEIGHT(600), .BIT_D(8), .DEPTH(16)) dut (
        .clk_i      (clk_i),
        .arst_n_i   (arst_n_i),
        .tdata_i    (tdata_i),
        .tvalid_i   (tvalid_i),
        .tlast_i    (tlast_i),
        .roi_w_i    (roi_w_i),
        .m_tdata_o  (m_tdata_o),
        .m_tvalid_o (m_tvalid_o),
        .m_tready_i (m_tready_i),
        .m_tuser_o  (m_tuser_o),
        .m_tlast_o  (m_tlast_o),
        .ovf_o      (ovf_o),
        .level_o    (level_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
        n_cmp++;
        assert (obs === want) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
        end
    endtask

    // Outputs are sampled on the falling edge; inputs only change just after rising edges.
    always @(negedge clk_i) begin
        if (!arst_n_i) begin
            prev_stall = 0;
        end else begin
            if (prev_stall)
                check("stall_hold", {29'd0, m_tvalid_o, m_tuser_o, m_tlast_o, m_tdata_o}, {21'd0, held});
            if (m_tvalid_o && m_tready_i) got.push_back({m_tuser_o, m_tlast_o, m_tdata_o});
            if (int'(level_o) > peak) peak = int'(level_o);
            prev_stall = m_tvalid_o && !m_tready_i;
            held = {m_tvalid_o, m_tuser_o, m_tlast_o, m_tdata_o};
        end
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
        if (toggle) m_tready_i = ~m_tready_i;
    endtask

    task automatic beat(input logic [7:0] d, input logic last, input logic [10:0] w);
        tdata_i  = d;
        tvalid_i = 1'b1;
        tlast_i  = last;
        roi_w_i  = w;
        tick();
        tvalid_i = 1'b0;
        tlast_i  = 1'b0;
    endtask

    task automatic expect_beat(input logic u, input logic l, input logic [7:0] d);
        exp_q.push_back({u, l, d});
    endtask

    task automatic drain_and_compare(input string tag);
        for (int c = 0; c < 300 && !(level_o == 5'd0 && got.size() >= exp_q.size()); c++) tick();
        check({tag, "_count"}, got.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got.size(); i++)
            check($sformatf("%s_beat%0d", tag, i), {22'd0, got[i]}, {22'd0, exp_q[i]});
        check({tag, "_level"}, {27'd0, level_o}, 32'd0);
        got.delete();
        exp_q.delete();
    endtask

    initial begin
        arst_n_i   = 1'b0;
        tdata_i    = '0;
        tvalid_i   = 1'b0;
        tlast_i    = 1'b0;
        roi_w_i    = '0;
        m_tready_i = 1'b0;
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        check("rst_tvalid", {31'd0, m_tvalid_o}, 32'd0);
        check("rst_level", {27'd0, level_o}, 32'd0);
        check("rst_ovf", {31'd0, ovf_o}, 32'd0);
        check("rst_side", {22'd0, m_tuser_o, m_tlast_o, m_tdata_o}, 32'd0);
        @(posedge clk_i);
        #1;
        arst_n_i = 1'b1;
        tick();

        // 12-beat frame, width 4, free-flowing output
        m_tready_i = 1'b1;
        for (int i = 0; i < 12; i++) begin
            beat(8'(i), i == 11, 11'd4);
            expect_beat(i == 0, (i % 4) == 3, 8'(i));
        end
        drain_and_compare("w4_ready");
        check("w4_ovf", {31'd0, ovf_o}, 32'd0);

        // same frame with downstream ready toggling every cycle
        peak = 0;
        toggle = 1;
        for (int i = 0; i < 12; i++) begin
            beat(8'(i), i == 11, 11'd4);
            expect_beat(i == 0, (i % 4) == 3, 8'(i));
        end
        drain_and_compare("w4_toggle");
        toggle = 0;
        m_tready_i = 1'b1;
        check("toggle_peak_ge2", {31'd0, peak >= 2}, 32'd1);

        // overflow: 20 beats into a 16-entry FIFO with no drain
        m_tready_i = 1'b0;
        for (int i = 0; i < 20; i++) begin
            beat(8'(i), i == 19, 11'd4);
            if (i == 15) begin
                check("full_level", {27'd0, level_o}, 32'd16);
                check("full_ovf_clear", {31'd0, ovf_o}, 32'd0);
            end
            if (i == 16) begin
                check("ovf_set", {31'd0, ovf_o}, 32'd1);
                check("ovf_level", {27'd0, level_o}, 32'd16);
            end
        end
        for (int i = 0; i < 16; i++) expect_beat(i == 0, (i % 4) == 3, 8'(i));
        m_tready_i = 1'b1;
        drain_and_compare("ovf_drain");
        check("ovf_sticky", {31'd0, ovf_o}, 32'd1);

        // width 5 with a short last line, then a new frame
        for (int i = 0; i < 8; i++) begin
            beat(8'(i), i == 7, 11'd5);
            expect_beat(i == 0, i == 4 || i == 7, 8'(i));
        end
        beat(8'd8, 1'b0, 11'd5);
        beat(8'd9, 1'b1, 11'd5);
        expect_beat(1'b1, 1'b0, 8'd8);
        expect_beat(1'b0, 1'b1, 8'd9);
        drain_and_compare("w5_short");

        // zero-width frame is dropped entirely
        for (int i = 0; i < 6; i++) beat(8'(8'h40 + i), i == 5, 11'd0);
        for (int i = 0; i < 3; i++) begin
            beat(8'(8'h10 + i), i == 2, 11'd3);
            expect_beat(i == 0, i == 2, 8'(8'h10 + i));
        end
        drain_and_compare("w0_then_w3");

        // reset in the middle of a frame
        m_tready_i = 1'b0;
        for (int i = 0; i < 5; i++) beat(8'(i), 1'b0, 11'd4);
        check("pre_rst_level", {27'd0, level_o}, 32'd5);
        arst_n_i = 1'b0;
        #1;
        check("midrst_tvalid", {31'd0, m_tvalid_o}, 32'd0);
        check("midrst_level", {27'd0, level_o}, 32'd0);
        check("midrst_ovf", {31'd0, ovf_o}, 32'd0);
        tick();
        arst_n_i = 1'b1;
        got.delete();
        exp_q.delete();
        m_tready_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            beat(8'(8'h20 + i), i == 3, 11'd4);
            expect_beat(i == 0, i == 3, 8'(8'h20 + i));
        end
        drain_and_compare("post_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
